// File: rtl/img_sram_arb.sv
// -----------------------------------------------------------------------------
// img_sram_arb
//   Two-requester arbiter and pin sequencer for the 256x256x8 image SRAM.
//   Requester 0 is the host image loader/unloader, requester 1 is the
//   convolution engine. Each requester offers one word request per cycle over
//   a valid/ready handshake. The granted request is turned into registered
//   SRAM pin values (hold / write / read) for the following cycle, and read
//   data is captured one clock after acceptance and returned with a per-
//   requester valid pulse. A bounded-burst round-robin keeps one requester
//   from starving the other.
//
// Ports
//   clk            single clock; the SRAM acts during the clk-low phase
//   rst_n          asynchronous active-low reset
//   req_valid[i]   requester i has a request
//   req_we[i]      1 = write, 0 = read
//   req_row/col    [8i+7:8i] address of requester i
//   req_wdata      [8i+7:8i] write data of requester i
//   req_ready[i]   request i accepted this cycle (combinational, one-hot-or-0)
//   rsp_valid[i]   rsp_rdata carries read data for requester i (1-cycle pulse)
//   rsp_rdata      registered read data, shared by both requesters
//   sram_*         registered SRAM control/address/data pins
//   sram_dout      SRAM read data, valid around the clk rising edge
// -----------------------------------------------------------------------------
module img_sram_arb #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_we,
    input  logic [15:0] req_row,
    input  logic [15:0] req_col,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        sram_write_en,
    output logic        sram_sense_en,
    output logic [7:0]  sram_row,
    output logic [7:0]  sram_col,
    output logic [7:0]  sram_din,
    input  logic [7:0]  sram_dout
);

    localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C  = CNT_W'(0);

    // Requester index to its one-hot handshake/response bit.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        logic [1:0] oh;
        if (idx) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

    // Arbiter state
    logic             owner_r;
    logic [CNT_W-1:0] burst_cnt_r;
    logic             owner_nxt_s;
    logic [CNT_W-1:0] burst_cnt_nxt_s;

    // Grant decision
    logic       grant_any_s;
    logic       grant_idx_s;

    // Fields of the granted requester
    logic       sel_we_s;
    logic [7:0] sel_row_s;
    logic [7:0] sel_col_s;
    logic [7:0] sel_wdata_s;

    // Next pin values
    logic       write_en_nxt_s;
    logic       sense_en_nxt_s;
    logic [7:0] row_nxt_s;
    logic [7:0] col_nxt_s;
    logic [7:0] din_nxt_s;

    // Read in flight: set at the accepting edge, consumed at the next edge
    logic       rd_pend_r;
    logic       rd_idx_r;
    logic       rd_pend_nxt_s;

    // Grant selection: single requester wins outright; on contention the
    // owner keeps the bus until it has used MAX_BURST consecutive grants.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_any_s = 1'b1;
                grant_idx_s = 1'b0;
            end
            2'b10: begin
                grant_any_s = 1'b1;
                grant_idx_s = 1'b1;
            end
            2'b11: begin
                grant_any_s = 1'b1;
                if (burst_cnt_r < BURST_MAX_C) begin
                    grant_idx_s = owner_r;
                end else begin
                    grant_idx_s = ~owner_r;
                end
            end
            default: begin
                grant_any_s = 1'b0;
                grant_idx_s = 1'b0;
            end
        endcase
    end

    // Handshake: ready mirrors the grant, so it is never set without valid.
    always_comb begin
        req_ready = 2'b00;
        if (grant_any_s) begin
            req_ready = idx_to_onehot(grant_idx_s);
        end else begin
            req_ready = 2'b00;
        end
    end

    // Mux out the granted requester's request fields.
    always_comb begin
        sel_we_s    = grant_idx_s ? req_we[1]         : req_we[0];
        sel_row_s   = grant_idx_s ? req_row[15:8]     : req_row[7:0];
        sel_col_s   = grant_idx_s ? req_col[15:8]     : req_col[7:0];
        sel_wdata_s = grant_idx_s ? req_wdata[15:8]   : req_wdata[7:0];
    end

    // Burst accounting: an idle cycle ends the burst but keeps the owner,
    // so the owner wins the next contention with a fresh budget.
    always_comb begin
        owner_nxt_s     = owner_r;
        burst_cnt_nxt_s = burst_cnt_r;
        if (!grant_any_s) begin
            owner_nxt_s     = owner_r;
            burst_cnt_nxt_s = CNT_ZERO_C;
        end else if (grant_idx_s == owner_r) begin
            owner_nxt_s = owner_r;
            if (burst_cnt_r < BURST_MAX_C) begin
                burst_cnt_nxt_s = burst_cnt_r + CNT_ONE_C;
            end else begin
                burst_cnt_nxt_s = burst_cnt_r;
            end
        end else begin
            owner_nxt_s     = grant_idx_s;
            burst_cnt_nxt_s = CNT_ONE_C;
        end
    end

    // Pin sequencing for the next cycle. write_en is only ever raised
    // together with sense_en, and din only changes on a write.
    always_comb begin
        write_en_nxt_s = 1'b0;
        sense_en_nxt_s = 1'b1;
        row_nxt_s      = sram_row;
        col_nxt_s      = sram_col;
        din_nxt_s      = sram_din;
        rd_pend_nxt_s  = 1'b0;
        if (grant_any_s) begin
            row_nxt_s = sel_row_s;
            col_nxt_s = sel_col_s;
            if (sel_we_s) begin
                write_en_nxt_s = 1'b1;
                sense_en_nxt_s = 1'b1;
                din_nxt_s      = sel_wdata_s;
                rd_pend_nxt_s  = 1'b0;
            end else begin
                write_en_nxt_s = 1'b0;
                sense_en_nxt_s = 1'b0;
                din_nxt_s      = sram_din;
                rd_pend_nxt_s  = 1'b1;
            end
        end else begin
            write_en_nxt_s = 1'b0;
            sense_en_nxt_s = 1'b1;
            rd_pend_nxt_s  = 1'b0;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r     <= 1'b0;
            burst_cnt_r <= CNT_ZERO_C;
        end else begin
            owner_r     <= owner_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    // SRAM pin registers; reset forces the hold state at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_write_en <= 1'b0;
            sram_sense_en <= 1'b1;
            sram_row      <= 8'h00;
            sram_col      <= 8'h00;
            sram_din      <= 8'h00;
        end else begin
            sram_write_en <= write_en_nxt_s;
            sram_sense_en <= sense_en_nxt_s;
            sram_row      <= row_nxt_s;
            sram_col      <= col_nxt_s;
            sram_din      <= din_nxt_s;
        end
    end

    // Track the read currently on the pins; reset drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_r <= 1'b0;
            rd_idx_r  <= 1'b0;
        end else begin
            rd_pend_r <= rd_pend_nxt_s;
            rd_idx_r  <= grant_idx_s;
        end
    end

    // Capture sram_dout at the edge closing the read's low phase; the data
    // register keeps its value between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 2'b00;
            rsp_rdata <= 8'h00;
        end else if (rd_pend_r) begin
            rsp_valid <= idx_to_onehot(rd_idx_r);
            rsp_rdata <= sram_dout;
        end else begin
            rsp_valid <= 2'b00;
            rsp_rdata <= rsp_rdata;
        end
    end

    img_sram_arb_chk u_chk (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .sram_write_en (sram_write_en),
        .sram_sense_en (sram_sense_en)
    );

endmodule

// -----------------------------------------------------------------------------
// img_sram_arb_chk
//   Protocol properties of img_sram_arb: one-hot-or-zero handshake and
//   response, no ready without valid, and no write with sense enabled low.
// Ports: observation-only copies of the arbiter's handshake and SRAM controls.
// -----------------------------------------------------------------------------
module img_sram_arb_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [1:0] req_valid,
    input logic [1:0] req_ready,
    input logic [1:0] rsp_valid,
    input logic       sram_write_en,
    input logic       sram_sense_en
);

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));

    a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
        ((req_ready & ~req_valid) == 2'b00));

    a_rsp_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(rsp_valid));

    a_no_write_while_sensing: assert property (@(posedge clk) disable iff (!rst_n)
        !(sram_write_en && !sram_sense_en));

endmodule

// File: tb/tb_img_sram_arb.sv
// -----------------------------------------------------------------------------
// tb_img_sram_arb
//   Directed bench for img_sram_arb with a behavioural 256x256x8 SRAM that
//   writes/reads during the clk-low phase. Inputs are driven 1 ns after the
//   rising edge; registered outputs are sampled at the same point, and the
//   combinational req_ready 1 ns later.
// -----------------------------------------------------------------------------
module tb_img_sram_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [15:0] req_row;
    logic [15:0] req_col;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        sram_write_en;
    logic        sram_sense_en;
    logic [7:0]  sram_row;
    logic [7:0]  sram_col;
    logic [7:0]  sram_din;
    logic [7:0]  sram_dout = 8'h00;

    logic [7:0]  mem [0:65535];

    int vec_cnt = 0;
    int err_cnt = 0;

    img_sram_arb #(.MAX_BURST(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_row       (req_row),
        .req_col       (req_col),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .sram_write_en (sram_write_en),
        .sram_sense_en (sram_sense_en),
        .sram_row      (sram_row),
        .sram_col      (sram_col),
        .sram_din      (sram_din),
        .sram_dout     (sram_dout)
    );

    always #5 clk = ~clk;

    // SRAM model: acts in the low phase
    always @(negedge clk) begin
        if (sram_write_en) begin
            mem[{sram_row, sram_col}] <= sram_din;
        end else if (!sram_sense_en) begin
            sram_dout <= mem[{sram_row, sram_col}];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pins(input string tag, input logic we, input logic se,
                            input logic [7:0] row, input logic [7:0] col, input logic [7:0] din);
        chk({tag, ".write_en"}, {15'd0, sram_write_en}, {15'd0, we});
        chk({tag, ".sense_en"}, {15'd0, sram_sense_en}, {15'd0, se});
        chk({tag, ".row"}, {8'd0, sram_row}, {8'd0, row});
        chk({tag, ".col"}, {8'd0, sram_col}, {8'd0, col});
        chk({tag, ".din"}, {8'd0, sram_din}, {8'd0, din});
    endtask

    task automatic chk_rsp(input string tag, input logic [1:0] rv, input logic [7:0] rd);
        chk({tag, ".rsp_valid"}, {14'd0, rsp_valid}, {14'd0, rv});
        chk({tag, ".rsp_rdata"}, {8'd0, rsp_rdata}, {8'd0, rd});
    endtask

    task automatic chk_ready(input string tag, input logic [1:0] exp);
        #1;
        chk({tag, ".ready"}, {14'd0, req_ready}, {14'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic we, input logic [7:0] row,
                           input logic [7:0] col, input logic [7:0] wd);
        req_valid[idx]         = 1'b1;
        req_we[idx]            = we;
        req_row[idx*8 +: 8]    = row;
        req_col[idx*8 +: 8]    = col;
        req_wdata[idx*8 +: 8]  = wd;
    endtask

    task automatic idle();
        req_valid = 2'b00;
    endtask

    initial begin
        logic [8:0] fair_pat;
        logic       g;
        logic       g_prev;

        rst_n     = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_row   = 16'h0000;
        req_col   = 16'h0000;
        req_wdata = 16'h0000;

        // Power-on reset
        #1 rst_n = 1'b0;
        #1;
        chk_pins("por", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        chk_rsp("por", 2'b00, 8'h00);
        chk("por.ready", {14'd0, req_ready}, 16'h0000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_pins("por_hold", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        chk_rsp("por_hold", 2'b00, 8'h00);

        // Requester 0: write then read back (0x12,0x34)
        set_req(0, 1'b1, 8'h12, 8'h34, 8'hA5);
        chk_ready("r0_wr", 2'b01);
        tick();
        idle();
        chk_pins("r0_wr", 1'b1, 1'b1, 8'h12, 8'h34, 8'hA5);
        chk_rsp("r0_wr", 2'b00, 8'h00);
        chk_ready("r0_idle", 2'b00);
        tick();
        chk_pins("r0_after_wr", 1'b0, 1'b1, 8'h12, 8'h34, 8'hA5);
        chk_rsp("r0_after_wr", 2'b00, 8'h00);
        set_req(0, 1'b0, 8'h12, 8'h34, 8'h00);
        chk_ready("r0_rd", 2'b01);
        tick();
        idle();
        chk_pins("r0_rd", 1'b0, 1'b0, 8'h12, 8'h34, 8'hA5);
        chk_rsp("r0_rd_lat0", 2'b00, 8'h00);
        tick();
        chk_rsp("r0_rd_lat1", 2'b01, 8'hA5);
        chk_pins("r0_rd_done", 1'b0, 1'b1, 8'h12, 8'h34, 8'hA5);
        tick();
        chk_rsp("r0_rd_pulse", 2'b00, 8'hA5);

        // Turnaround: r0 writes (255,255) while r1 waits to read it
        set_req(0, 1'b1, 8'hFF, 8'hFF, 8'h3C);
        set_req(1, 1'b0, 8'hFF, 8'hFF, 8'h00);
        chk_ready("ta_wr", 2'b01);
        tick();
        req_valid[0] = 1'b0;
        chk_pins("ta_wr", 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h3C);
        chk_ready("ta_rd", 2'b10);
        tick();
        idle();
        chk_pins("ta_rd", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h3C);
        tick();
        chk_rsp("ta_rsp", 2'b10, 8'h3C);
        tick();
        chk_rsp("ta_pulse", 2'b00, 8'h3C);

        // Requester 1: three writes, then three back-to-back reads
        for (int i = 0; i < 6; i++) begin
            logic [7:0] a;
            a = 8'(i % 3);
            set_req(1, (i < 3) ? 1'b1 : 1'b0, 8'h00, a, 8'h10 + a);
            chk_ready($sformatf("b2b%0d", i), 2'b10);
            tick();
            if (i < 3) begin
                chk_pins($sformatf("b2b%0d", i), 1'b1, 1'b1, 8'h00, a, 8'h10 + a);
                chk_rsp($sformatf("b2b%0d", i), 2'b00, 8'h3C);
            end else begin
                chk_pins($sformatf("b2b%0d", i), 1'b0, 1'b0, 8'h00, a, 8'h12);
                if (i == 3) begin
                    chk_rsp("b2b3", 2'b00, 8'h3C);
                end else begin
                    chk_rsp($sformatf("b2b%0d", i), 2'b10, 8'(8'h10 + 8'(i - 4)));
                end
            end
        end
        idle();
        tick();
        chk_rsp("b2b_last", 2'b10, 8'h12);
        tick();
        chk_rsp("b2b_end", 2'b00, 8'h12);

        // Reset in the middle of a read
        set_req(1, 1'b0, 8'h00, 8'h01, 8'h00);
        chk_ready("mid_rd", 2'b10);
        tick();
        idle();
        chk_pins("mid_rd", 1'b0, 1'b0, 8'h00, 8'h01, 8'h12);
        #2 rst_n = 1'b0;
        #1;
        chk_pins("mid_rst", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        chk_rsp("mid_rst", 2'b00, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        chk_rsp("mid_drop", 2'b00, 8'h00);
        chk_pins("mid_hold", 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        tick();
        chk_rsp("mid_hold2", 2'b00, 8'h00);

        // Burst fairness: both reading continuously, r0 owns after reset
        fair_pat = 9'b0_1111_0000;
        g_prev   = 1'b0;
        set_req(0, 1'b0, 8'h00, 8'h00, 8'h00);
        set_req(1, 1'b0, 8'hFF, 8'hFF, 8'h00);
        for (int k = 0; k < 9; k++) begin
            g = fair_pat[k];
            chk_ready($sformatf("fair%0d", k), g ? 2'b10 : 2'b01);
            tick();
            chk_pins($sformatf("fair%0d", k), 1'b0, 1'b0, g ? 8'hFF : 8'h00,
                     g ? 8'hFF : 8'h00, 8'h00);
            if (k == 0) begin
                chk_rsp("fair0", 2'b00, 8'h00);
            end else begin
                chk_rsp($sformatf("fair%0d", k), g_prev ? 2'b10 : 2'b01,
                        g_prev ? 8'h3C : 8'h10);
            end
            g_prev = g;
        end
        idle();
        tick();
        chk_rsp("fair_last", 2'b01, 8'h10);

        // Idle break: r1 granted twice, an idle cycle, then contention
        set_req(1, 1'b0, 8'h00, 8'h02, 8'h00);
        chk_ready("brk0", 2'b10);
        tick();
        chk_ready("brk1", 2'b10);
        tick();
        idle();
        chk_rsp("brk1_rsp", 2'b10, 8'h12);
        tick();
        chk_rsp("brk_idle", 2'b10, 8'h12);
        set_req(0, 1'b0, 8'h12, 8'h34, 8'h00);
        set_req(1, 1'b0, 8'h00, 8'h02, 8'h00);
        chk_ready("brk_both", 2'b10);
        tick();
        idle();
        chk_pins("brk_both", 1'b0, 1'b0, 8'h00, 8'h02, 8'h00);
        tick();
        chk_rsp("brk_rsp", 2'b10, 8'h12);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/img_sram_arb.md
Name: img_sram_arb

Overview:
- Two-requester arbiter and sequencer for the 256x256x8 image SRAM.
- Requester 0 is the host image loader/unloader; requester 1 is the convolution engine.
- Converts per-requester valid/ready word requests into SRAM pin sequencing: hold, write (clk-low phase) and read (clk-low phase, dout sampled at the next rising edge).
- Returns registered read data, with bounded-burst round-robin fairness between the two requesters.

Parameters:
- MAX_BURST, 4, max consecutive grants to one requester while the other is waiting (>=1).
- CNT_W, $clog2(MAX_BURST+1), burst counter width (derived; do not override).

Ports:
- clk  in  1  single clock; SRAM write/read occur in the low phase.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  bit i: requester i has a request.
- req_we  in  2  bit i: 1 = write, 0 = read.
- req_row  in  16  [8i+7:8i] row address of requester i.
- req_col  in  16  [8i+7:8i] column address of requester i.
- req_wdata  in  16  [8i+7:8i] write data of requester i.
- req_ready  out  2  bit i: request i accepted this cycle (combinational).
- rsp_valid  out  2  bit i: rsp_rdata holds read data for requester i.
- rsp_rdata  out  8  read data, shared by both requesters.
- sram_write_en  out  1  SRAM write_en.
- sram_sense_en  out  1  SRAM sense_en.
- sram_row  out  8  SRAM row address.
- sram_col  out  8  SRAM column address.
- sram_din  out  8  SRAM write data.
- sram_dout  in  8  SRAM read data; valid only around clk rising edge.

Behaviour:
- Reset (async, rst_n=0):
  - sram_write_en=0, sram_sense_en=1 (hold).
  - sram_row/col/din=0.
  - rsp_valid=0, rsp_rdata=0.
  - owner=0, burst_cnt=0.
- Handshake:
  - A transfer happens on the rising edge where req_valid[i]&req_ready[i].
  - req_ready has at most one bit set.
  - req_ready[i] never asserts unless req_valid[i]=1.
  - No backpressure: one request per cycle, back-to-back allowed.
- Arbitration (combinational grant g):
  - Neither valid: no grant.
  - One valid: grant it.
  - Both valid: grant owner if burst_cnt<MAX_BURST, else grant the other requester.
- Arbiter state update at the edge:
  - Grant to owner: burst_cnt += 1, saturating at MAX_BURST.
  - Grant to the other requester: owner := that requester, burst_cnt := 1.
  - No grant: burst_cnt := 0, owner unchanged.
- SRAM sequencing (all pins registered). For a request accepted at edge N, the pins are held for cycle N..N+1:
  - Write: write_en=1, sense_en=1, row/col/din from the granted requester.
  - Read: write_en=0, sense_en=0, row/col from the granted requester; din holds its previous value.
  - No acceptance at edge N: write_en=0, sense_en=1; row/col/din hold previous values.
- Read response:
  - At edge N+1, rsp_rdata := sram_dout and rsp_valid[g]:=1; visible during cycle N+1..N+2.
  - Latency is 1 clock from acceptance.
  - rsp_valid is a one-cycle pulse per read.
  - Writes produce no response.
  - rsp_rdata holds its value when rsp_valid=0.
- Back-to-back reads from alternating requesters give consecutive rsp_valid pulses with the correct bit set. Response order equals acceptance order.
- write_en=1 with sense_en=0 is never driven.
- Reset mid-operation:
  - An in-flight read's response is dropped.
  - Pins return to hold immediately (async).
  - No partial write is guaranteed beyond the current low phase.
- Addresses 0..255 are used as given; there is no wrap logic.

Test Plan:
- Reset: rst_n=0 mid-read -> pins immediately write_en=0/sense_en=1, row=col=din=0, rsp_valid=00. Released with valid=00 -> stays in hold.
- Single write then read, requester 0:
  - Write row=0x12, col=0x34, data=0xA5 -> one cycle of write_en=1/sense_en=1 with din=0xA5.
  - Then a read of the same address -> rsp_valid=01, rsp_rdata=0xA5 exactly 1 cycle after acceptance.
- Back-to-back reads: requester 1 reads addresses (0,0),(0,1),(0,2) preloaded with 0x10,0x11,0x12 -> ready held 3 cycles; rsp_valid=10 for 3 consecutive cycles with data 0x10,0x11,0x12.
- Burst fairness, MAX_BURST=4: both valid continuously, both reading -> grant pattern 0,0,0,0,1,1,1,1,0...; each rsp_valid bit matches its grant.
- Idle break: requester 1 granted twice, one idle cycle, then both valid -> requester 1 (owner, burst_cnt=0) is granted next.
- Write/read turnaround: requester 0 writes 0x3C to (255,255) while requester 1 is queued to read (255,255) -> the read is granted the next cycle and returns 0x3C.
